// File: rtl/rr_mux_arbiter.sv
// Round-robin N:1 vector mux with a single registered output stage.
// Define RR_MUX_ARBITER_LOCK_EN to add in_lock, which pins the grant to one requester.
module rr_mux_arbiter #(
  parameter int BIT_WIDTH   = 8,
  parameter int NUM_VECTORS = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_VECTORS-1:0]          in_valid,
  input  logic [NUM_VECTORS*BIT_WIDTH-1:0] in_data,
`ifdef RR_MUX_ARBITER_LOCK_EN
  input  logic [NUM_VECTORS-1:0]          in_lock,
`endif
  output logic [NUM_VECTORS-1:0]          in_ready,
  output logic                            out_valid,
  output logic [BIT_WIDTH-1:0]            out_data,
  output logic [$clog2(NUM_VECTORS)-1:0]  out_sel,
  input  logic                            out_ready
);
  localparam int SEL_W = $clog2(NUM_VECTORS);

  logic                   out_valid_q, out_valid_d;
  logic [BIT_WIDTH-1:0]   out_data_q, out_data_d;
  logic [SEL_W-1:0]       out_sel_q, out_sel_d;
  logic [SEL_W-1:0]       ptr_q, ptr_d;
  logic [NUM_VECTORS-1:0] elig;
  logic                   grant_vld;
  logic [SEL_W-1:0]       grant_idx;
  logic                   load;
  logic                   xfer;

`ifdef RR_MUX_ARBITER_LOCK_EN
  logic lock_q, lock_d;
  // While locked, ptr already points at the owner, so only that bit stays eligible.
  assign elig = lock_q ? (in_valid & (NUM_VECTORS'(1) << ptr_q)) : in_valid;
`else
  assign elig = in_valid;
`endif

  // Search from ptr upward; the reverse loop lets the closest requester win.
  always_comb begin
    logic [SEL_W-1:0] idx;
    idx       = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = NUM_VECTORS - 1; k >= 0; k--) begin
      idx = ptr_q + SEL_W'(k);
      if (elig[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  assign load     = !reset && (!out_valid_q || out_ready);
  assign xfer     = load && grant_vld;
  assign in_ready = xfer ? (NUM_VECTORS'(1) << grant_idx) : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
`ifdef RR_MUX_ARBITER_LOCK_EN
    lock_d      = lock_q;
`endif
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(grant_idx)*BIT_WIDTH +: BIT_WIDTH];
      out_sel_d   = grant_idx;
      ptr_d       = grant_idx + SEL_W'(1);
`ifdef RR_MUX_ARBITER_LOCK_EN
      lock_d      = in_lock[grant_idx];
      if (in_lock[grant_idx]) ptr_d = grant_idx;
`endif
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
`ifdef RR_MUX_ARBITER_LOCK_EN
      lock_q      <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
`ifdef RR_MUX_ARBITER_LOCK_EN
      lock_q      <= lock_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter (BIT_WIDTH=8, NUM_VECTORS=4, data 1/10/20/30).
module tb_rr_mux_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;
`ifdef RR_MUX_ARBITER_LOCK_EN
  logic [3:0]  in_lock;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rr_mux_arbiter #(.BIT_WIDTH(8), .NUM_VECTORS(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
`ifdef RR_MUX_ARBITER_LOCK_EN
    .in_lock(in_lock),
`endif
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and land 1ns after it, away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic [1:0] s);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".data"}, 32'(out_data), 32'(d));
    chk({tag, ".sel"}, 32'(out_sel), 32'(s));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] s1_data [5];
    logic [1:0] s1_sel [5];
    s1_data = '{8'd1, 8'd10, 8'd20, 8'd30, 8'd1};
    s1_sel  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    in_data   = {8'd30, 8'd20, 8'd10, 8'd1};
    in_valid  = 4'hF;
    out_ready = 1'b1;
`ifdef RR_MUX_ARBITER_LOCK_EN
    in_lock   = 4'h0;
`endif

    // Reset state, with requests present to show in_ready stays low.
    reset = 1'b1;
    tick();
    tick();
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.data", 32'(out_data), 32'd0);
    chk("rst.sel", 32'(out_sel), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;

    // Scenario 1: all valid, strict rotation with wrap.
    chk("s1.in_ready0", 32'(in_ready), 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out($sformatf("s1.beat%0d", i), s1_data[i], s1_sel[i]);
    end

    // Scenario 2: lone req2, then req1+req3 -> req3 first.
    in_valid = 4'b0100;
    do_reset();
    tick();
    chk_out("s2.req2", 8'd20, 2'd2);
    in_valid = 4'b1010;
    tick();
    chk_out("s2.req3", 8'd30, 2'd3);
    tick();
    chk_out("s2.req1", 8'd10, 2'd1);

    // Scenario 3: stall three cycles holding 10, then release with no bubble.
    out_ready = 1'b0;
    in_valid  = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("s3.stall%0d.in_ready", i), 32'(in_ready), 32'd0);
      tick();
      chk_out($sformatf("s3.stall%0d", i), 8'd10, 2'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("s3.release.in_ready", 32'(in_ready), 32'b0100);
    tick();
    chk_out("s3.nobubble", 8'd20, 2'd2);

    // Scenario 5: no requests -> EMPTY, data/sel/ptr hold.
    in_valid = 4'h0;
    tick();
    chk("s5.valid", 32'(out_valid), 32'd0);
    chk("s5.data_hold", 32'(out_data), 32'd20);
    chk("s5.sel_hold", 32'(out_sel), 32'd2);
    in_valid = 4'hF;
    #1;
    chk("s5.ptr_hold", 32'(in_ready), 32'b1000);
    tick();
    chk_out("s5.resume", 8'd30, 2'd3);

    // Scenario 4: reset while FULL at ptr=2.
    in_valid = 4'b0010;
    tick();
    chk_out("s4.full", 8'd10, 2'd1);
    in_valid = 4'hF;
    reset = 1'b1;
    #1;
    chk("s4.rst.in_ready", 32'(in_ready), 32'd0);
    tick();
    reset = 1'b0;
    chk("s4.valid", 32'(out_valid), 32'd0);
    chk("s4.data", 32'(out_data), 32'd0);
    chk("s4.sel", 32'(out_sel), 32'd0);
    tick();
    chk_out("s4.first", 8'd1, 2'd0);

`ifdef RR_MUX_ARBITER_LOCK_EN
    // Scenario 6: req1 locks for three beats, then releases to req2.
    in_valid = 4'b0001;
    do_reset();
    tick();
    chk_out("s6.setup", 8'd1, 2'd0);
    in_valid = 4'b0111;
    in_lock  = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("s6.lock%0d", i), 8'd10, 2'd1);
      chk($sformatf("s6.lock%0d.in_ready", i), 32'(in_ready), 32'b0010);
    end
    in_lock = 4'b0000;
    tick();
    chk_out("s6.unlock", 8'd10, 2'd1);
    tick();
    chk_out("s6.next", 8'd20, 2'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
